// File: rtl/uart_rx_channel.sv
// uart_rx_channel: 3-flop input synchronizer, 16x-oversampling 8N1 receiver
// and a Gray-pointer dual-clock FIFO that hands received bytes to rd_clk.
// Line status (frame / overrun) lives in the uart_clk domain.
module uart_rx_channel #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  uart_clk,
  input  logic                  uart_rst_n,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  sample_tick,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  rd_empty,
  output logic                  rx_full,
  output logic                  rx_active,
  output logic [3:0]            rx_level,
  output logic                  frame_error,
  output logic                  overrun_error,
  input  logic                  fifo_reset
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  // Full when the pointers differ only in their two MSBs (Gray wrap rule)
  localparam logic [PW-1:0] FULL_MASK = PW'(2'd3) << (PW - 2);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  logic [2:0]            rx_sync_r;
  logic                  rx_s;
  rx_state_t             state_r, state_next_s;
  logic [3:0]            tick_cnt_r;
  logic [BCW-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  cnt_clear_s, data_sample_s, stop_sample_s;
  logic                  wr_req_s, wr_en_s;
  logic                  rx_active_r, frame_error_r, overrun_r;

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wbin_r, wgray_r, wbin_next_s, wgray_next_s;
  logic [PW-1:0]         rq1_r, rq2_r;
  logic                  rx_full_r;
  logic [PW-1:0]         rx_level_r;
  logic [PW-1:0]         rbin_r, rgray_r, rbin_next_s, rgray_next_s;
  logic [PW-1:0]         wq1_r, wq2_r;
  logic                  rd_empty_r;

  // Input synchronizer; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) rx_sync_r <= 3'b111;
    else             rx_sync_r <= {rx_sync_r[1:0], rx_serial};
  end

  assign rx_s = rx_sync_r[2];

  // Receiver state register
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) state_r <= ST_IDLE;
    else             state_r <= state_next_s;
  end

  // Receiver next state: only sample_tick cycles advance the frame
  always_comb begin
    state_next_s = state_r;
    if (sample_tick) begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) state_next_s = ST_START;
          else       state_next_s = ST_IDLE;
        end
        ST_START: begin
          if (tick_cnt_r == 4'd7) state_next_s = rx_s ? ST_IDLE : ST_DATA;
          else                    state_next_s = ST_START;
        end
        ST_DATA: begin
          if (tick_cnt_r == 4'd15 && bit_cnt_r == BCW'(DATA_WIDTH - 1)) state_next_s = ST_STOP;
          else                                                          state_next_s = ST_DATA;
        end
        ST_STOP: begin
          if (tick_cnt_r == 4'd15) state_next_s = ST_IDLE;
          else                     state_next_s = ST_STOP;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Receiver outputs: counter restart and the data/stop sampling strobes
  always_comb begin
    cnt_clear_s   = 1'b0;
    data_sample_s = 1'b0;
    stop_sample_s = 1'b0;
    if (sample_tick) begin
      case (state_r)
        ST_IDLE:  cnt_clear_s = 1'b1;
        ST_START: cnt_clear_s = (tick_cnt_r == 4'd7);
        ST_DATA: begin
          data_sample_s = (tick_cnt_r == 4'd15);
          cnt_clear_s   = (tick_cnt_r == 4'd15);
        end
        ST_STOP: begin
          stop_sample_s = (tick_cnt_r == 4'd15);
          cnt_clear_s   = (tick_cnt_r == 4'd15);
        end
        default: cnt_clear_s = 1'b1;
      endcase
    end else begin
      cnt_clear_s = 1'b0;
    end
  end

  assign wr_req_s = stop_sample_s & rx_s;
  assign wr_en_s  = wr_req_s & ~rx_full_r;

  // Tick/bit counters and LSB-first shift register
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      tick_cnt_r <= 4'd0;
      bit_cnt_r  <= {BCW{1'b0}};
      shift_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      if (sample_tick) tick_cnt_r <= cnt_clear_s ? 4'd0 : tick_cnt_r + 4'd1;
      if (state_r != ST_DATA) begin
        bit_cnt_r <= {BCW{1'b0}};
      end else if (data_sample_s) begin
        bit_cnt_r <= bit_cnt_r + BCW'(1'b1);
        shift_r   <= {rx_s, shift_r[DATA_WIDTH-1:1]};
      end
    end
  end

  // Line status: busy flag, per-frame stop-bit result, sticky overrun
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      rx_active_r   <= 1'b0;
      frame_error_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      rx_active_r <= (state_next_s != ST_IDLE);
      if (stop_sample_s) frame_error_r <= ~rx_s;
      if (wr_req_s && rx_full_r) overrun_r <= 1'b1;
    end
  end

  assign wbin_next_s  = wbin_r + PW'(wr_en_s);
  assign wgray_next_s = bin2gray(wbin_next_s);

  // FIFO storage, written at the valid stop-bit sample; deliberately not reset
  always_ff @(posedge uart_clk) begin
    if (wr_en_s) mem_r[wbin_r[AW-1:0]] <= shift_r;
  end

  // Read pointer brought into the write domain
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      rq1_r <= {PW{1'b0}};
      rq2_r <= {PW{1'b0}};
    end else begin
      rq1_r <= rgray_r;
      rq2_r <= rq1_r;
    end
  end

  // Write pointer, full flag and conservative occupancy
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      wbin_r     <= {PW{1'b0}};
      wgray_r    <= {PW{1'b0}};
      rx_full_r  <= 1'b0;
      rx_level_r <= {PW{1'b0}};
    end else begin
      wbin_r     <= wbin_next_s;
      wgray_r    <= wgray_next_s;
      rx_full_r  <= (wgray_next_s == (rq2_r ^ FULL_MASK));
      rx_level_r <= wbin_next_s - gray2bin(rq2_r);
    end
  end

  // Read pointer next value: flush jumps to the synced write pointer
  always_comb begin
    if (fifo_reset) begin
      rbin_next_s = gray2bin(wq2_r);
    end else if (rd_en && !rd_empty_r) begin
      rbin_next_s = rbin_r + PW'(1'b1);
    end else begin
      rbin_next_s = rbin_r;
    end
  end

  assign rgray_next_s = bin2gray(rbin_next_s);

  // Write pointer brought into the read domain
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wq1_r <= {PW{1'b0}};
      wq2_r <= {PW{1'b0}};
    end else begin
      wq1_r <= wgray_r;
      wq2_r <= wq1_r;
    end
  end

  // Read pointer and empty flag
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rbin_r     <= {PW{1'b0}};
      rgray_r    <= {PW{1'b0}};
      rd_empty_r <= 1'b1;
    end else begin
      rbin_r     <= rbin_next_s;
      rgray_r    <= rgray_next_s;
      rd_empty_r <= (rgray_next_s == wq2_r);
    end
  end

  assign rd_data       = mem_r[rbin_r[AW-1:0]];
  assign rd_empty      = rd_empty_r;
  assign rx_full       = rx_full_r;
  assign rx_level      = 4'(rx_level_r);
  assign rx_active     = rx_active_r;
  assign frame_error   = frame_error_r;
  assign overrun_error = overrun_r;

endmodule

// File: tb/tb_uart_rx_channel.sv
// Bench for uart_rx_channel: serial frames driven bit by bit, expected
// bytes and status kept in a queue-based reference model.
module tb_uart_rx_channel;

  localparam int DEPTH = 8;
  localparam int CLKS_PER_BIT = 32;  // 16 ticks per bit, tick every 2nd uart_clk

  logic       uart_clk    = 1'b0;
  logic       uart_rst_n  = 1'b0;
  logic       rd_clk      = 1'b0;
  logic       rd_rst_n    = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx_serial   = 1'b1;
  logic       rd_en       = 1'b0;
  logic       fifo_reset  = 1'b0;
  logic [7:0] rd_data;
  logic       rd_empty, rx_full, rx_active, frame_error, overrun_error;
  logic [3:0] rx_level;

  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       m_overrun = 1'b0;
  logic       m_fe      = 1'b0;
  logic       active_mid = 1'b0;

  uart_rx_channel #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .uart_clk     (uart_clk),
    .uart_rst_n   (uart_rst_n),
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .sample_tick  (sample_tick),
    .rx_serial    (rx_serial),
    .rd_data      (rd_data),
    .rd_en        (rd_en),
    .rd_empty     (rd_empty),
    .rx_full      (rx_full),
    .rx_active    (rx_active),
    .rx_level     (rx_level),
    .frame_error  (frame_error),
    .overrun_error(overrun_error),
    .fifo_reset   (fifo_reset)
  );

  initial forever #5 uart_clk = ~uart_clk;
  initial forever #7 rd_clk = ~rd_clk;
  initial forever begin
    @(posedge uart_clk);
    #1;
    sample_tick = ~sample_tick;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic uclk(input int n);
    repeat (n) @(posedge uart_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    uclk(CLKS_PER_BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      uclk(CLKS_PER_BIT / 2);
      if (i == 4) active_mid = rx_active;
      uclk(CLKS_PER_BIT / 2);
    end
    drive_bit(stop);
    rx_serial = 1'b1;
  endtask

  // Reference model: a good frame enters the queue if room, otherwise overrun
  task automatic send_model(input logic [7:0] d, input logic stop);
    send_frame(d, stop);
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                      m_overrun = 1'b1;
      m_fe = 1'b0;
    end else begin
      m_fe = 1'b1;
      drive_bit(1'b1);
      drive_bit(1'b1);
    end
  endtask

  task automatic check_status(input string tag);
    uclk(8);
    check({tag, ".level"}, 32'(rx_level), 32'(exp_q.size()));
    check({tag, ".full"}, 32'(rx_full), 32'(exp_q.size() == DEPTH));
    check({tag, ".ovr"}, 32'(overrun_error), 32'(m_overrun));
    check({tag, ".fe"}, 32'(frame_error), 32'(m_fe));
    check({tag, ".empty"}, 32'(rd_empty), 32'(exp_q.size() == 0));
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    int waited = 0;
    @(negedge rd_clk);
    while (rd_empty && waited < 40) begin
      @(negedge rd_clk);
      waited++;
    end
    check({tag, ".avail"}, 32'(rd_empty), 32'd0);
    check({tag, ".data"}, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic pop_model(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    pop_check(tag, e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".active"}, 32'(rx_active), 32'd0);
    check({tag, ".fe"}, 32'(frame_error), 32'd0);
    check({tag, ".ovr"}, 32'(overrun_error), 32'd0);
    check({tag, ".full"}, 32'(rx_full), 32'd0);
    check({tag, ".level"}, 32'(rx_level), 32'd0);
    check({tag, ".empty"}, 32'(rd_empty), 32'd1);
  endtask

  initial begin
    uclk(4);
    check_reset_vals("rst");
    uart_rst_n = 1'b1;
    rd_rst_n   = 1'b1;
    uclk(4);

    // Single byte, busy flag, read-back and empty after pop
    send_model(8'hA5, 1'b1);
    check("a5.active_mid", 32'(active_mid), 32'd1);
    check_status("a5");
    pop_model("a5");
    @(negedge rd_clk);
    check("a5.empty_after", 32'(rd_empty), 32'd1);

    // Nine bytes into a depth-8 FIFO: full, overrun, ordered drain
    for (int i = 1; i <= 9; i++) send_model(8'(i), 1'b1);
    check_status("ovr");
    for (int i = 0; i < DEPTH; i++) pop_model("ovr_rd");
    check_status("ovr_drained");

    // Bad stop bit, then a good frame clears the error
    send_model(8'h3C, 1'b0);
    check_status("fe");
    send_model(8'h55, 1'b1);
    check_status("fe_ok");
    pop_model("fe_ok");

    // Short low glitch must be rejected
    rx_serial = 1'b0;
    uclk(8);
    rx_serial = 1'b1;
    uclk(40);
    check("glitch.active", 32'(rx_active), 32'd0);
    check_status("glitch");

    // Random bytes with randomly interleaved reads
    repeat (10) begin
      send_model(8'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 1) == 1) pop_model("rnd");
    end
    check_status("rnd");
    while (exp_q.size() > 0) pop_model("rnd_drain");

    // Read-side flush
    repeat (3) send_model(8'($urandom_range(0, 255)), 1'b1);
    check_status("flush_pre");
    @(negedge rd_clk);
    fifo_reset = 1'b1;
    @(posedge rd_clk);
    #1;
    fifo_reset = 1'b0;
    check("flush.empty", 32'(rd_empty), 32'd1);
    exp_q.delete();
    check_status("flush_post");
    send_model(8'h77, 1'b1);
    pop_model("flush_77");

    // Reset in the middle of a data phase
    send_model(8'h3C, 1'b0);
    rx_serial = 1'b0;
    uclk(CLKS_PER_BIT);
    rx_serial = 1'b1;
    uclk(2 * CLKS_PER_BIT);
    check("mid.active", 32'(rx_active), 32'd1);
    uart_rst_n = 1'b0;
    rd_rst_n   = 1'b0;
    uclk(3);
    check_reset_vals("mid_rst");
    uclk(200);
    uart_rst_n = 1'b1;
    rd_rst_n   = 1'b1;
    exp_q.delete();
    m_overrun = 1'b0;
    m_fe      = 1'b0;
    uclk(4);
    check_status("post_rst");
    send_model(8'hC3, 1'b1);
    check_status("c3");
    pop_model("c3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
